// File: rtl/vga_sync_decoder.sv
// vga_sync_decoder
// Recovers pixel coordinates and colour from a DE/HSYNC/VSYNC display
// stream, checks line/frame geometry against the expected active size and
// reports timing lock.
//
// Ports:
//   pixel_clk, rst_n          clock, synchronous active-low reset
//   h_sync, v_sync            sync inputs, polarity set by SYNC_ACTIVE_LOW
//   disp_enbl                 1 = active pixel
//   red/green/blue [3:0]      pixel colour
//   pix_valid                 recovered pixel inside the expected active area
//   pix_x [10:0], pix_y [9:0] recovered coordinates
//   pix_r/g/b [3:0]           colour aligned with pix_valid
//   frame_start, line_end     pulses on first pixel of frame / last of line
//   locked                    timing locked
//   sync_err                  pulse on a bad line or bad frame
//
// Pipeline: stage 1 registers the raw inputs, stage 2 registers every output,
// so each output reflects the input sampled two clocks earlier.
module vga_sync_decoder #(
  parameter int H_ACTIVE        = 800,
  parameter int V_ACTIVE        = 600,
  parameter int LOCK_FRAMES     = 2,
  parameter int SYNC_ACTIVE_LOW = 1
) (
  input  logic        pixel_clk,
  input  logic        rst_n,
  input  logic        h_sync,
  input  logic        v_sync,
  input  logic        disp_enbl,
  input  logic [3:0]  red,
  input  logic [3:0]  green,
  input  logic [3:0]  blue,
  output logic        pix_valid,
  output logic [10:0] pix_x,
  output logic [9:0]  pix_y,
  output logic [3:0]  pix_r,
  output logic [3:0]  pix_g,
  output logic [3:0]  pix_b,
  output logic        frame_start,
  output logic        line_end,
  output logic        locked,
  output logic        sync_err
);

  localparam int GW = (LOCK_FRAMES > 0) ? $clog2(LOCK_FRAMES + 1) : 1;
  localparam logic [GW-1:0] LOCK_N  = GW'(LOCK_FRAMES);
  localparam logic [11:0]   H_CNT   = 12'(H_ACTIVE);
  localparam logic [10:0]   V_LINES = 11'(V_ACTIVE);

  typedef enum logic [1:0] {IDLE, SEARCH, LOCKED} state_t;

  // Horizontal sync carries no information the decoder needs: line
  // boundaries come from disp_enbl edges.
  logic unused_h_sync;
  assign unused_h_sync = h_sync;

  // stage 1
  logic        vs_q, vs_d, vs_prev_q;
  logic        de_q, de_prev_q;
  logic [11:0] rgb_q;
  // counters / FSM
  logic [10:0] h_cnt_q, h_cnt_d;
  logic [9:0]  v_cnt_q, v_cnt_d;
  logic        bad_seen_q, bad_seen_d;
  state_t      state_q, state_d;
  logic [GW-1:0] good_q, good_d;
  // stage 2
  logic        pix_valid_q, pix_valid_d;
  logic [10:0] pix_x_q, pix_x_d;
  logic [9:0]  pix_y_q, pix_y_d;
  logic [11:0] rgb_out_q;
  logic        frame_start_q, frame_start_d;
  logic        line_end_q, line_end_d;
  logic        locked_q, locked_d;
  logic        sync_err_q, sync_err_d;

  // combinational helpers
  logic        v_edge, de_rise, de_fall, active;
  logic [10:0] x_cur;
  logic [9:0]  y_cur;
  logic [11:0] pix_cnt;
  logic [10:0] lines_closed;
  logic        line_bad, frame_bad;

  always_comb begin
    vs_d    = (SYNC_ACTIVE_LOW != 0) ? ~v_sync : v_sync;
    v_edge  = vs_q & ~vs_prev_q;
    de_rise = de_q & ~de_prev_q;
    de_fall = ~de_q & de_prev_q;
    active  = (state_q != IDLE);

    // h_cnt_q holds the x of the last active sample, so x+1 is the
    // pixel count of the line that just closed.
    x_cur   = de_rise ? 11'd0 : ((h_cnt_q == 11'h7FF) ? h_cnt_q : h_cnt_q + 11'd1);
    h_cnt_d = de_q ? x_cur : h_cnt_q;
    pix_cnt = {1'b0, h_cnt_q} + 12'd1;

    y_cur = v_edge ? 10'd0 : v_cnt_q;
    // A line ending on the same sample as the vsync edge belongs to the
    // frame being closed.
    lines_closed = {1'b0, v_cnt_q} + {10'd0, de_fall};

    line_bad  = (de_fall & (pix_cnt != H_CNT)) | (v_edge & de_q);
    frame_bad = bad_seen_q | line_bad | (lines_closed != V_LINES);

    if (v_edge)       v_cnt_d = 10'd0;
    else if (de_fall) v_cnt_d = (v_cnt_q == 10'h3FF) ? v_cnt_q : v_cnt_q + 10'd1;
    else              v_cnt_d = v_cnt_q;

    bad_seen_d = v_edge ? 1'b0 : (bad_seen_q | line_bad);

    state_d = state_q;
    good_d  = good_q;
    case (state_q)
      IDLE: if (v_edge) begin
        // first edge only aligns to the stream, nothing to judge yet
        state_d = SEARCH;
        good_d  = '0;
      end
      SEARCH: if (v_edge) begin
        if (frame_bad) good_d = '0;
        else begin
          good_d = good_q + GW'(1);
          if (good_d == LOCK_N) state_d = LOCKED;
        end
      end
      LOCKED: if (line_bad | (v_edge & frame_bad)) begin
        state_d = SEARCH;
        good_d  = '0;
      end
      default: begin
        state_d = IDLE;
        good_d  = '0;
      end
    endcase

    pix_valid_d   = active & de_q & ({1'b0, x_cur} < H_CNT) & ({1'b0, y_cur} < V_LINES);
    pix_x_d       = de_q ? x_cur : 11'd0;
    pix_y_d       = de_q ? y_cur : 10'd0;
    frame_start_d = pix_valid_d & (x_cur == 11'd0) & (y_cur == 10'd0);
    // the raw input is the sample that follows the one in stage 1
    line_end_d    = pix_valid_d & ~disp_enbl;
    locked_d      = (state_q == LOCKED);
    sync_err_d    = active & (line_bad | (v_edge & frame_bad));
  end

  always_ff @(posedge pixel_clk) begin
    if (!rst_n) begin
      vs_q          <= 1'b0;
      vs_prev_q     <= 1'b0;
      de_q          <= 1'b0;
      de_prev_q     <= 1'b0;
      rgb_q         <= '0;
      h_cnt_q       <= '0;
      v_cnt_q       <= '0;
      bad_seen_q    <= 1'b0;
      state_q       <= IDLE;
      good_q        <= '0;
      pix_valid_q   <= 1'b0;
      pix_x_q       <= '0;
      pix_y_q       <= '0;
      rgb_out_q     <= '0;
      frame_start_q <= 1'b0;
      line_end_q    <= 1'b0;
      locked_q      <= 1'b0;
      sync_err_q    <= 1'b0;
    end else begin
      vs_q          <= vs_d;
      vs_prev_q     <= vs_q;
      de_q          <= disp_enbl;
      de_prev_q     <= de_q;
      rgb_q         <= {red, green, blue};
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      bad_seen_q    <= bad_seen_d;
      state_q       <= state_d;
      good_q        <= good_d;
      pix_valid_q   <= pix_valid_d;
      pix_x_q       <= pix_x_d;
      pix_y_q       <= pix_y_d;
      rgb_out_q     <= rgb_q;
      frame_start_q <= frame_start_d;
      line_end_q    <= line_end_d;
      locked_q      <= locked_d;
      sync_err_q    <= sync_err_d;
    end
  end

  assign pix_valid   = pix_valid_q;
  assign pix_x       = pix_x_q;
  assign pix_y       = pix_y_q;
  assign pix_r       = rgb_out_q[11:8];
  assign pix_g       = rgb_out_q[7:4];
  assign pix_b       = rgb_out_q[3:0];
  assign frame_start = frame_start_q;
  assign line_end    = line_end_q;
  assign locked      = locked_q;
  assign sync_err    = sync_err_q;

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Bench for vga_sync_decoder: two instances (active-low and active-high
// sync polarity) see the same stream; an event-level reference model
// predicts every output and a monitor compares two clocks later.
module tb_vga_sync_decoder;
  localparam int H = 16, V = 6, LF = 2, HB = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n = 1'b0, hs = 1'b0, vs = 1'b0, de = 1'b0;
  logic [3:0] r = '0, g = '0, b = '0;

  logic        v0, v1, fs0, fs1, le0, le1, lk0, lk1, er0, er1;
  logic [10:0] x0, x1;
  logic [9:0]  y0, y1;
  logic [3:0]  r0, g0, b0, r1, g1, b1;

  vga_sync_decoder #(.H_ACTIVE(H), .V_ACTIVE(V), .LOCK_FRAMES(LF), .SYNC_ACTIVE_LOW(1)) dut0 (
    .pixel_clk(clk), .rst_n(rst_n), .h_sync(~hs), .v_sync(~vs), .disp_enbl(de),
    .red(r), .green(g), .blue(b), .pix_valid(v0), .pix_x(x0), .pix_y(y0),
    .pix_r(r0), .pix_g(g0), .pix_b(b0), .frame_start(fs0), .line_end(le0),
    .locked(lk0), .sync_err(er0));

  vga_sync_decoder #(.H_ACTIVE(H), .V_ACTIVE(V), .LOCK_FRAMES(LF), .SYNC_ACTIVE_LOW(0)) dut1 (
    .pixel_clk(clk), .rst_n(rst_n), .h_sync(hs), .v_sync(vs), .disp_enbl(de),
    .red(r), .green(g), .blue(b), .pix_valid(v1), .pix_x(x1), .pix_y(y1),
    .pix_r(r1), .pix_g(g1), .pix_b(b1), .frame_start(fs1), .line_end(le1),
    .locked(lk1), .sync_err(er1));

  typedef struct {
    bit full; bit valid; int x; int y; int cr; int cg; int cb;
    bit fs; bit le; bit lk; bit err; int due;
  } exp_t;

  exp_t q[$];
  int ncyc = 0, checks = 0, errors = 0;

  // reference model: state 0 idle, 1 searching, 2 locked
  int st = 0, gcnt = 0, px = 0, lines = 0;
  bit pde = 0, pvs = 0, badseen = 0;

  task automatic chk(int id, string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL dut%0d %s: got %0d expected %0d (cycle %0d)", id, nm, act, exp, ncyc);
    end
  endtask

  task automatic cmp(int id, exp_t e, logic vl, logic [10:0] x, logic [9:0] y,
                     logic [3:0] cr, logic [3:0] cg, logic [3:0] cb,
                     logic fs, logic le, logic lk, logic er);
    chk(id, "pix_valid", int'(vl), int'(e.valid));
    chk(id, "frame_start", int'(fs), int'(e.fs));
    chk(id, "line_end", int'(le), int'(e.le));
    chk(id, "locked", int'(lk), int'(e.lk));
    chk(id, "sync_err", int'(er), int'(e.err));
    if (e.valid || e.full) begin
      chk(id, "pix_x", int'(x), e.x);
      chk(id, "pix_y", int'(y), e.y);
      chk(id, "pix_r", int'(cr), e.cr);
      chk(id, "pix_g", int'(cg), e.cg);
      chk(id, "pix_b", int'(cb), e.cb);
    end
  endtask

  // monitor: compare each prediction on the falling edge two clocks after
  // its input was presented
  always @(negedge clk) begin
    exp_t e;
    while (q.size() > 0 && q[0].due <= ncyc) begin
      e = q.pop_front();
      cmp(0, e, v0, x0, y0, r0, g0, b0, fs0, le0, lk0, er0);
      cmp(1, e, v1, x1, y1, r1, g1, b1, fs1, le1, lk1, er1);
    end
    ncyc++;
  end

  // one input sample plus its predicted response
  task automatic drive(bit rst, bit vv, bit dd);
    exp_t e, t;
    bit vedge, dfall, lbad, fbad;
    int x, y;
    @(posedge clk); #1;
    rst_n = !rst; vs = vv; de = dd;
    hs = !dd && ($urandom_range(0, 1) == 1);
    r = 4'($urandom); g = 4'($urandom); b = 4'($urandom);
    e = '{default: 0};
    e.due = ncyc + 2;
    if (q.size() > 0) begin
      t = q[q.size()-1];
      t.le = t.valid && !dd;
      q[q.size()-1] = t;
    end
    if (rst) begin
      // the output register loaded on this edge is cleared as well
      if (q.size() > 0 && q[q.size()-1].due == ncyc + 1) begin
        t = '{default: 0};
        t.full = 1; t.due = ncyc + 1;
        q[q.size()-1] = t;
      end
      e.full = 1;
      st = 0; gcnt = 0; px = 0; lines = 0; pde = 0; pvs = 0; badseen = 0;
    end else begin
      vedge = vv && !pvs;
      dfall = !dd && pde;
      x = 0;
      if (dd) x = pde ? px + 1 : 0;
      lbad = (dfall && (px + 1 != H)) || (vedge && dd);
      fbad = badseen || lbad || (lines + int'(dfall) != V);
      y = vedge ? 0 : lines;
      e.valid = (st != 0) && dd && x < H && y < V;
      e.x = x; e.y = y; e.cr = int'(r); e.cg = int'(g); e.cb = int'(b);
      e.fs = e.valid && x == 0 && y == 0;
      e.lk = (st == 2);
      e.err = (st != 0) && (lbad || (vedge && fbad));
      if (dd) px = x;
      lines = vedge ? 0 : lines + int'(dfall);
      badseen = vedge ? 1'b0 : (badseen | lbad);
      case (st)
        0: if (vedge) begin st = 1; gcnt = 0; end
        1: if (vedge) begin
             if (fbad) gcnt = 0;
             else begin gcnt++; if (gcnt == LF) st = 2; end
           end
        default: if (lbad || (vedge && fbad)) begin st = 1; gcnt = 0; end
      endcase
      pde = dd; pvs = vv;
    end
    q.push_back(e);
  endtask

  task automatic line(int len);
    repeat (HB) drive(0, 0, 0);
    repeat (len) drive(0, 0, 1);
  endtask

  // vsync, back porch, nl lines (line bad_ln gets bad_len pixels), front porch
  task automatic send_frame(int nl, int bad_ln, int bad_len, int fp);
    repeat (3) drive(0, 1, 0);
    repeat (HB * 3) drive(0, 0, 0);
    for (int l = 0; l < nl; l++) line((l == bad_ln) ? bad_len : H);
    repeat (fp) drive(0, 0, 0);
  endtask

  initial begin
    int nl, bl, blen;
    repeat (3) drive(1, 0, 0);
    // nominal timing: lock after two judged frames
    repeat (5) send_frame(V, -1, 0, 4);
    // one short line while locked, then relock
    send_frame(V, 2, H - 1, 4);
    repeat (4) send_frame(V, -1, 0, 4);
    // one line too many
    send_frame(V + 1, -1, 0, 4);
    repeat (4) send_frame(V, -1, 0, 4);
    // vsync edge in the middle of an active line
    repeat (3) drive(0, 1, 0);
    repeat (HB * 3) drive(0, 0, 0);
    line(H); line(H);
    line(5);
    repeat (3) drive(0, 1, 1);
    repeat (2) drive(0, 1, 0);
    repeat (6) drive(0, 0, 0);
    repeat (4) send_frame(V, -1, 0, 4);
    // last line ends on the vsync edge sample
    send_frame(V, -1, 0, 0);
    repeat (3) send_frame(V, -1, 0, 0);
    // one-cycle reset mid-line while locked
    repeat (3) drive(0, 1, 0);
    repeat (HB * 3) drive(0, 0, 0);
    line(H); line(H);
    line(6);
    drive(1, 0, 1);
    repeat (H - 7) drive(0, 0, 1);
    line(H); line(H);
    repeat (4) drive(0, 0, 0);
    repeat (4) send_frame(V, -1, 0, 4);
    // random geometry
    for (int f = 0; f < 12; f++) begin
      nl = ($urandom_range(0, 9) < 7) ? V : V - 1 + 2 * $urandom_range(0, 1);
      bl = ($urandom_range(0, 3) == 0) ? $urandom_range(0, V - 1) : -1;
      blen = H - 3 + $urandom_range(0, 6);
      send_frame(nl, bl, blen, $urandom_range(0, 5));
    end
    repeat (4) drive(0, 0, 0);
    // bounded drain of outstanding predictions
    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/vga_sync_decoder.md
VGA_SYNC_DECODER -- requirements
Module: vga_sync_decoder

Interface
REQ-001 Parameter H_ACTIVE, default 800: expected active pixels per line.
REQ-002 Parameter V_ACTIVE, default 600: expected active lines per frame.
REQ-003 Parameter LOCK_FRAMES, default 2: consecutive good frames required to assert locked.
REQ-004 Parameter SYNC_ACTIVE_LOW, default 1: 1 = h_sync/v_sync asserted when low.
REQ-005 pixel_clk  in  1  pixel clock (36 MHz); one clock domain only; all logic on rising edge.
REQ-006 rst_n  in  1  reset, synchronous and active-low.
REQ-007 h_sync  in  1  horizontal sync from the display timing generator.
REQ-008 v_sync  in  1  vertical sync from the display timing generator.
REQ-009 disp_enbl  in  1  display enable; 1 = active pixel.
REQ-010 red, green, blue  in  4 each  pixel colour, valid when disp_enbl=1.
REQ-011 pix_valid  out  1  recovered pixel valid.
REQ-012 pix_x  out  11  recovered horizontal coordinate.
REQ-013 pix_y  out  10  recovered vertical coordinate.
REQ-014 pix_r, pix_g, pix_b  out  4 each  colour aligned with pix_valid.
REQ-015 frame_start  out  1  one-cycle pulse with first valid pixel of a frame (x=0, y=0).
REQ-016 line_end  out  1  one-cycle pulse with last active pixel of each line.
REQ-017 locked  out  1  timing locked.
REQ-018 sync_err  out  1  one-cycle pulse on any detected line or frame error.

Function
REQ-019 All inputs registered once (stage 1); all outputs registered (stage 2); input-to-output latency exactly 2 cycles.
REQ-020 Sync inputs normalised by SYNC_ACTIVE_LOW; v_sync assertion edge = normalised 0->1 between consecutive stage-1 samples.
REQ-021 Horizontal counter: cleared to 0 on disp_enbl rising edge; +1 per cycle while disp_enbl=1; saturates at 2047.
REQ-022 Line counter: cleared to 0 on v_sync assertion edge; +1 on each disp_enbl falling edge; saturates at 1023.
REQ-023 pix_x/pix_y = horizontal/line counter values of the sampled pixel; pix_r/g/b = sampled colour.
REQ-024 pix_valid=1 only when state != IDLE, disp_enbl=1, x < H_ACTIVE and y < V_ACTIVE.
REQ-025 line_end=1 when pix_valid=1 and the next stage-1 sample has disp_enbl=0; line_end is not gated by line length.
REQ-026 Line check at disp_enbl falling edge: pixel count != H_ACTIVE -> line bad, sync_err pulse.
REQ-027 Frame check at v_sync assertion edge: line count != V_ACTIVE or any bad line since previous edge -> frame bad, sync_err pulse (single pulse if both fire in one cycle).
REQ-028 v_sync assertion edge while disp_enbl=1 -> line bad and frame bad.
REQ-029 disp_enbl falling edge and v_sync assertion edge in same cycle: the line is counted into the closing frame before the counter clears.
REQ-030 FSM states IDLE, SEARCH, LOCKED; good-frame counter width ceil(log2(LOCK_FRAMES+1)).
REQ-031 IDLE -> SEARCH on first v_sync assertion edge; counter=0; no frame check on that edge.
REQ-032 SEARCH: good frame -> counter+1; counter reaching LOCK_FRAMES -> LOCKED; bad frame -> counter=0, stay.
REQ-033 LOCKED: any bad line -> SEARCH immediately, counter=0; bad frame -> SEARCH.
REQ-034 locked=1 exactly when state=LOCKED, updated on the cycle after the transition.
REQ-035 sync_err never pulses in IDLE.

Reset
REQ-036 rst_n=0 at a clock edge: state=IDLE, all counters=0, pipeline registers cleared; every output 0 (pix_x=0, pix_y=0, colours 0, pulses 0, locked=0).
REQ-037 Reset mid-frame discards the partial frame; decoder requires a new v_sync edge before pix_valid asserts.

Verification
REQ-038 Reset then nominal timing 1024x625, 800x600 active: locked=1 after 2nd post-first-vsync frame; frame_start once per frame; pix_x 0..799, pix_y 0..599; RGB matches input 2 cycles earlier.
REQ-039 Locked, one line with 799 active pixels: sync_err pulse at its de fall; locked=0 next cycle; relock after 2 good frames.
REQ-040 Frame with 601 active lines: pix_valid=0 on line 600; sync_err at next v_sync edge; not locked from SEARCH.
REQ-041 v_sync asserted while disp_enbl=1: one sync_err pulse; state to SEARCH.
REQ-042 rst_n low for 1 cycle mid-frame in LOCKED: all outputs 0; no pix_valid until next v_sync edge; locked after 2 more good frames.
REQ-043 SYNC_ACTIVE_LOW=0 with inverted syncs: identical results to REQ-038.
